reg_write_arbiter: RTL
======================

# reg_write_arbiter

Round-robin write arbiter that shares a small bank of 8-bit write-enabled registers among several requesters. Each requester raises a request with an address and a data byte; the arbiter grants one requester per clock edge, performs the register write on that edge, and returns a one-cycle acknowledge. It sits between independent producer blocks and the register bank, replacing direct `we` control of the registers so that no two writers collide.

## Interface
- `N`, 4: number of requesters (2..8).
- `W`, 8: data width of each register.
- `NREG`, 4: number of registers in the bank (power of two, ≥2); `AW = log2(NREG)`.

- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  N  request per requester; bit i belongs to requester i.
- `waddr`  in  N*AW  requester i's register address in bits [i*AW +: AW].
- `wdata`  in  N*W  requester i's data in bits [i*W +: W].
- `ack`  out  N  one-hot or zero; bit i high for one cycle after requester i's write.
- `grant_id`  out  3  index of the last granted requester.
- `grant_valid`  out  1  high for one cycle after any write (equals |ack).
- `reg_out`  out  NREG*W  current register contents; register k in bits [k*W +: W].
- `write_count`  out  16  total writes performed since reset.

## Operation
- Clock and reset are fixed as stated: one clock `clock`; `reset_n` is asynchronous and active-low.
- Reset values: all registers 0, `ack` 0, `grant_id` 0, `grant_valid` 0, `write_count` 0, and the round-robin pointer `ptr` 0.
- Eligibility at each rising edge: requester i is eligible iff `req[i]`=1 and `ack[i]`=0. A requester acknowledged in the previous cycle is masked for one edge.
- Selection: the first eligible index scanning `ptr`, `ptr+1`, … mod N is the winner. With no eligible requester, nothing changes except `ack`/`grant_valid`, which clear to 0.
- On a win by requester i:
  - the register `reg[waddr_i]` is loaded with `wdata_i`;
  - `ack` is set to one-hot i, `grant_valid` to 1 and `grant_id` to i;
  - `ptr` is set to (i+1) mod N;
  - `write_count` increments and wraps from 0xFFFF to 0.
- Handshake: the requester holds `req`, `waddr` and `wdata` stable until it sees `ack[i]`=1. It may then drop `req`, or keep it high with new data to issue its next write, which is eligible from the following edge.
- At most one register write per cycle. Multiple requesters targeting the same address are serialized in grant order, so the last granted value persists.
- Registers are never written except through a grant. Values hold indefinitely.
- `reg_out` is a direct view of the register flops, with no read latency.
- Asserting `reset_n` low at any time, including mid-handshake, clears state immediately. A request pending at reset must be re-presented; it is granted normally after `reset_n` rises.

## Timing
- Write latency: 1 edge. A request sampled at edge t is written at edge t when it wins, and `reg_out` and `ack` reflect it in cycle t..t+1.
- Worst-case wait with all N requesters continuously requesting: N edges between grants to the same requester.
- A single requester alone holding `req` high gets a write every other edge, because of ack masking.
- Outputs are all registered. No combinational path runs from `req`/`wdata` to any output.
- The pointer advances only on a grant. Idle cycles do not rotate priority.

## Test plan
- **Reset and idle:** hold `reset_n`=0 for 3 cycles, then release with `req`=0.
  - Required response: all `reg_out`=0, `ack`=0 and `write_count`=0 for 10 cycles.
- **Single write:** requester 2 raises `req` with `waddr`=1 and `wdata`=8'd7.
  - Required response: after the next edge, reg1=7, `ack`=4'b0100 and `grant_id`=2 for exactly one cycle, and `write_count`=1.
- **Full contention:** all 4 requesters assert `req` simultaneously, each with `waddr`=i and `wdata`=i+10, holding until their ack.
  - Required response: grants in order 0,1,2,3 on consecutive edges; reg0..3 = 10,11,12,13; `write_count`=4.
- **Same-address collision:** requesters 1 and 3 both target reg0 with 8'd12 and 8'd5, with `ptr`=0.
  - Required response: requester 1 is granted first, then requester 3; final reg0=5.
- **Fairness and masking:** requester 0 holds `req` continuously while requester 1 requests once.
  - Required response: requester 1 is granted within 2 edges, and requester 0 never receives `ack` on two consecutive cycles.
- **Reset mid-operation:** pull `reset_n` low between edges while `req`=4'b1111.
  - Required response: all outputs read 0 immediately, without waiting for a clock edge.
  - After release, grants restart from requester 0.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that serializes register writes from N requesters into a
// small bank of W-bit registers; one write per clock and a one-cycle ack per grant.
module reg_write_arbiter #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int NREG = 4,
  localparam int AW  = $clog2(NREG)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [N-1:0]       req,
  input  logic [N*AW-1:0]    waddr,
  input  logic [N*W-1:0]     wdata,
  output logic [N-1:0]       ack,
  output logic [2:0]         grant_id,
  output logic               grant_valid,
  output logic [NREG*W-1:0]  reg_out,
  output logic [15:0]        write_count
);

  logic [W-1:0]  reg_q [NREG];
  logic [N-1:0]  ack_q, ack_d;
  logic [2:0]    grant_id_q, grant_id_d;
  logic          grant_valid_q, grant_valid_d;
  logic [15:0]   write_count_q, write_count_d;
  logic [2:0]    ptr_q, ptr_d;

  logic [7:0]    elig;
  logic [3:0]    cand;
  logic [3:0]    nxt;
  logic          win;
  logic [2:0]    win_id;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;

  always_comb begin
    // A requester acked last cycle sits out one edge so it cannot hog the bank.
    elig          = 8'(req & ~ack_q);
    cand          = '0;
    win           = 1'b0;
    win_id        = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + 4'(k);
      if (cand >= 4'(N)) cand = cand - 4'(N);
      if (!win && elig[cand[2:0]]) begin
        win    = 1'b1;
        win_id = cand[2:0];
      end
    end

    wr_addr       = waddr[win_id*AW +: AW];
    wr_data       = wdata[win_id*W +: W];
    nxt           = {1'b0, win_id} + 4'd1;
    if (nxt >= 4'(N)) nxt = '0;

    ack_d         = '0;
    grant_valid_d = 1'b0;
    grant_id_d    = grant_id_q;
    ptr_d         = ptr_q;
    write_count_d = write_count_q;
    if (win) begin
      ack_d         = N'(1) << win_id;
      grant_valid_d = 1'b1;
      grant_id_d    = win_id;
      ptr_d         = nxt[2:0];
      write_count_d = write_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREG; r++) reg_q[r] <= '0;
      ack_q         <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      write_count_q <= '0;
      ptr_q         <= '0;
    end else begin
      if (win) reg_q[wr_addr] <= wr_data;
      ack_q         <= ack_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      write_count_q <= write_count_d;
      ptr_q         <= ptr_d;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_view
    assign reg_out[g*W +: W] = reg_q[g];
  end

  assign ack         = ack_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = grant_valid_q;
  assign write_count = write_count_q;

endmodule
